line_mem: RTL and testbench
===========================

# line_mem

Line-granular backing memory that sits directly downstream of the set-associative cache/TLB and serves its miss traffic. It accepts one line read (swap-in) or one line write (swap-out) at a time over a level request / single-pulse grant handshake. It models a fixed access latency followed by a word-serial burst. It holds `2^ADDR_LEN` lines of `2^LINE_ADDR_LEN` 32-bit words in an internal array.

## Interface
Parameters:
- `LINE_ADDR_LEN`, 3: log2 words per line; `LINE_SIZE = 1 << LINE_ADDR_LEN`.
- `ADDR_LEN`, 7: line address width; depth = `2^ADDR_LEN` lines.
- `LATENCY`, 4: wait cycles before the burst; 0 is legal and skips the wait.

Ports:
- `clk` in 1: single clock; everything is on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `gnt` out 1: one-cycle pulse; the transaction is complete.
- `addr` in `ADDR_LEN`: line address, sampled only at accept.
- `rd_req` in 1: line read request, level, held until `gnt`.
- `rd_line` out `32 x LINE_SIZE`: read line buffer.
- `wr_req` in 1: line write request, level, held until `gnt`.
- `wr_line` in `32 x LINE_SIZE`: write data, sampled only at accept.

## Operation
- States are IDLE, WAIT, XFER and DONE.
- **IDLE**
  - If `wr_req` is high: latch `addr` and the whole `wr_line` into the write buffer, set op = write, and go to WAIT (or XFER if `LATENCY == 0`).
  - Else if `rd_req` is high: latch `addr`, set op = read, same transition.
  - Otherwise stay in IDLE.
  - When both requests are high, the write wins. `rd_req` stays high and is accepted in a later IDLE cycle.
- **WAIT**: counts `LATENCY` cycles, then goes to XFER with the word index at 0.
- **XFER**: moves exactly one word per cycle, at index `i = 0 .. LINE_SIZE-1`.
  - Read: `rd_line[i] <= mem[{addr_q, i}]`.
  - Write: `mem[{addr_q, i}] <= wbuf[i]`.
  - After `i = LINE_SIZE-1`, go to DONE.
- **DONE**: `gnt = 1` for exactly this cycle, then IDLE.
- Request inputs are ignored outside IDLE.
  - A change of `addr` or `wr_line` mid-transaction has no effect.
  - Dropping a request mid-transaction does not abort it: the transaction completes and `gnt` still pulses.
- **`rd_line` stability**
  - `rd_line` is updated only during a read XFER. Words become final one per cycle.
  - It holds all words from the DONE cycle until the next read's XFER begins.
  - Write transactions never touch `rd_line`.
  - The cache therefore captures it in the cycle after `gnt`.
- **Address wrap**: the word index is `LINE_ADDR_LEN` bits and wraps within the line. Line addresses are used as-is; there is no out-of-range case.
- **Reset**
  - Reset values: `gnt = 0`, every `rd_line` word = 0, state IDLE, wait counter 0, word index 0, write buffer 0.
  - Reset mid-transaction aborts the transaction and no `gnt` is issued.
  - Words already committed by a write XFER stay written; the remaining words are unchanged.

## Timing
- Cycle 0 is the IDLE cycle in which the request is sampled high.
- WAIT occupies cycles 1..`LATENCY`.
- XFER occupies cycles `LATENCY+1` .. `LATENCY+LINE_SIZE`.
- `gnt` is high in cycle `LATENCY+LINE_SIZE+1`; with the defaults this is cycle 13.
- `gnt` is a registered state decode (DONE), not combinational from the inputs.
- Back-to-back: IDLE is re-entered in the cycle after `gnt`. A request already high in that cycle is accepted there (e.g. the cache's swap-out followed immediately by swap-in), so the turnaround costs 1 cycle.
- Throughput: one line per `LATENCY+LINE_SIZE+2` cycles.

## Configuration
- Macro: `LINE_MEM_INIT_EN`.
- Defined: on every `rst` cycle each word is also set to `mem[{line, i}] = {line, i}` zero-extended to 32 bits, so the bench has known contents.
- Not defined: reset leaves the array untouched, uninitialized at power-up (X in simulation). Control and output reset behaviour is identical in both builds.

## Test plan
- `LINE_MEM_INIT_EN` build, reset, read line 5 → `gnt` in cycle 13 only, and `rd_line[i] = 0x28 + i` (`{5, i}`).
- Write line 3 with `wr_line[i] = 0xA0+i` → `gnt` in cycle 13. Then read line 3 → `rd_line[i] = 0xA0+i`; `rd_line` is unchanged between the two `gnt` pulses.
- `rd_req` and `wr_req` both high on line 2 → the write completes first (`gnt` in cycle 13). The read is accepted in cycle 14 and returns the written data, `gnt` in cycle 27.
- Change `addr` and `wr_line` during WAIT and XFER → the original line is written and the other lines are unchanged.
- Assert `rst` during write XFER after 3 words → no `gnt`, state IDLE, `rd_line = 0`. Words 0–2 hold the new data; with the macro off, words 3–7 keep their old data.
- `LATENCY = 0` → `gnt` in cycle 9. Drop `rd_req` after the accept cycle → `gnt` is still issued.

Source files
------------

// File: rtl/line_mem_if.sv
// rtl/line_mem_if.sv - line request/grant bus between the cache and line_mem
// The master side is the cache; the slave side is the backing memory.
interface line_mem_if #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 7
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;

    logic                        gnt;
    logic [ADDR_LEN-1:0]         addr;
    logic                        rd_req;
    logic                        wr_req;
    logic [LINE_SIZE-1:0][31:0]  rd_line;
    logic [LINE_SIZE-1:0][31:0]  wr_line;

    modport master (
        output addr, rd_req, wr_req, wr_line,
        input  gnt, rd_line
    );

    modport slave (
        input  addr, rd_req, wr_req, wr_line,
        output gnt, rd_line
    );
endinterface

// File: rtl/line_mem.sv
// rtl/line_mem.sv - line-granular backing memory with fixed latency and word-serial burst
// Optional macro LINE_MEM_INIT_EN: reset also loads every word with its own word address.
module line_mem #(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 7,
    parameter int LATENCY       = 4
) (
    input  logic       clk,
    input  logic       rst,
    line_mem_if.slave  bus
);
    localparam int LINE_SIZE = 1 << LINE_ADDR_LEN;
    localparam int MEM_WORDS = 1 << (ADDR_LEN + LINE_ADDR_LEN);
    localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
    localparam logic [LINE_ADDR_LEN-1:0] IDX_LAST = LINE_ADDR_LEN'(LINE_SIZE - 1);

    typedef enum logic [1:0] {IDLE, WAIT, XFER, DONE} state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [LINE_ADDR_LEN-1:0]    idx_q, idx_d;
    logic [ADDR_LEN-1:0]         addr_q, addr_d;
    logic                        op_wr_q, op_wr_d;
    logic [LINE_SIZE-1:0][31:0]  wbuf_q, wbuf_d;
    logic [LINE_SIZE-1:0][31:0]  rd_line_q, rd_line_d;

    logic [31:0]                          mem [0:MEM_WORDS-1];
    logic [ADDR_LEN+LINE_ADDR_LEN-1:0]    mem_addr;
    logic                                 mem_we;

    assign mem_addr    = {addr_q, idx_q};
    assign bus.gnt     = (state_q == DONE);
    assign bus.rd_line = rd_line_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        addr_d    = addr_q;
        op_wr_d   = op_wr_q;
        wbuf_d    = wbuf_q;
        rd_line_d = rd_line_q;
        mem_we    = 1'b0;
        case (state_q)
            IDLE: begin
                // Write has priority; a concurrent read stays pending on its level.
                if (bus.wr_req) begin
                    addr_d  = bus.addr;
                    wbuf_d  = bus.wr_line;
                    op_wr_d = 1'b1;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (LATENCY == 0) ? XFER : WAIT;
                end else if (bus.rd_req) begin
                    addr_d  = bus.addr;
                    op_wr_d = 1'b0;
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = (LATENCY == 0) ? XFER : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = XFER;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            XFER: begin
                if (op_wr_q) begin
                    mem_we = 1'b1;
                end else begin
                    rd_line_d[idx_q] = mem[mem_addr];
                end
                idx_d = idx_q + LINE_ADDR_LEN'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            op_wr_q   <= 1'b0;
            wbuf_q    <= '0;
            rd_line_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            addr_q    <= addr_d;
            op_wr_q   <= op_wr_d;
            wbuf_q    <= wbuf_d;
            rd_line_q <= rd_line_d;
        end
    end

    // Reset blocks the in-flight word so an aborted write commits only earlier words.
    always_ff @(posedge clk) begin
`ifdef LINE_MEM_INIT_EN
        if (rst) begin
            for (int j = 0; j < MEM_WORDS; j++) begin
                mem[j] <= 32'(j);
            end
        end else
`endif
        if (mem_we && !rst) begin
            mem[mem_addr] <= wbuf_q[idx_q];
        end
    end
endmodule

// File: tb/tb_line_mem.sv
// tb/tb_line_mem.sv - directed self-checking bench for line_mem
module tb_line_mem;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    line_mem_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(7)) if0 ();
    line_mem_if #(.LINE_ADDR_LEN(3), .ADDR_LEN(7)) if1 ();

    line_mem #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .LATENCY(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    line_mem #(.LINE_ADDR_LEN(3), .ADDR_LEN(7), .LATENCY(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [255:0] pat(input logic [31:0] base);
        logic [255:0] p;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = base + 32'(i);
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int which, input bit wr, input bit rd,
                         input logic [6:0] a, input logic [255:0] l);
        if (which == 0) begin
            if0.wr_req = wr; if0.rd_req = rd; if0.addr = a; if0.wr_line = l;
        end else begin
            if1.wr_req = wr; if1.rd_req = rd; if1.addr = a; if1.wr_line = l;
        end
    endtask

    function automatic logic get_gnt(input int which);
        return (which == 0) ? if0.gnt : if1.gnt;
    endfunction

    // Counts negedges from the current one until gnt is seen; -1 on timeout.
    task automatic wait_gnt(input int which, output int cyc);
        logic g;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            g = get_gnt(which);
        end while (g !== 1'b1 && cyc < 60);
        if (g !== 1'b1) cyc = -1;
    endtask

    task automatic txn(input int which, input bit wr, input logic [6:0] a,
                       input logic [255:0] l, input int exp_cyc, input string tag);
        int c;
        drive(which, wr, !wr, a, l);
        wait_gnt(which, c);
        drive(which, 1'b0, 1'b0, a, l);
        chk({tag, "_gnt_cycle"}, 256'(c), 256'(exp_cyc));
        @(negedge clk);
        chk({tag, "_gnt_pulse"}, 256'(get_gnt(which)), 256'(0));
    endtask

    initial begin
        int c;
        int gcount;
        logic [255:0] mixed;
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 7'd0, '0);
        drive(1, 1'b0, 1'b0, 7'd0, '0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("reset_gnt", 256'(if0.gnt), 256'(0));
        chk("reset_rd_line", if0.rd_line, '0);

        txn(0, 1'b1, 7'd5, pat(32'h28), 13, "wr5");
        chk("wr5_rd_line_untouched", if0.rd_line, '0);
        txn(0, 1'b0, 7'd5, '0, 13, "rd5");
        chk("rd5_data", if0.rd_line, pat(32'h28));

        drive(0, 1'b1, 1'b0, 7'd3, pat(32'hA0));
        wait_gnt(0, c);
        drive(0, 1'b0, 1'b0, 7'd3, '0);
        chk("wr3_gnt_cycle", 256'(c), 256'(13));
        chk("wr3_rd_line_at_gnt", if0.rd_line, pat(32'h28));
        @(negedge clk);
        chk("wr3_rd_line_after", if0.rd_line, pat(32'h28));
        txn(0, 1'b0, 7'd3, '0, 13, "rd3");
        chk("rd3_data", if0.rd_line, pat(32'hA0));

        drive(0, 1'b1, 1'b1, 7'd2, pat(32'hB0));
        wait_gnt(0, c);
        chk("both_wr_gnt_cycle", 256'(c), 256'(13));
        drive(0, 1'b0, 1'b1, 7'd2, '0);
        wait_gnt(0, c);
        drive(0, 1'b0, 1'b0, 7'd2, '0);
        chk("both_rd_gnt_cycle", 256'(c + 13), 256'(27));
        chk("both_rd_data", if0.rd_line, pat(32'hB0));
        @(negedge clk);

        txn(0, 1'b1, 7'd7, pat(32'hD0), 13, "wr7");
        drive(0, 1'b1, 1'b0, 7'd6, pat(32'hE0));
        c = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 2) drive(0, 1'b1, 1'b0, 7'd7, pat(32'hFFFF0000));
            if (k == 7) drive(0, 1'b1, 1'b0, 7'd5, pat(32'h55550000));
            if (if0.gnt === 1'b1) begin
                c = k;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 7'd0, '0);
        chk("midchg_gnt_cycle", 256'(c), 256'(13));
        @(negedge clk);
        txn(0, 1'b0, 7'd6, '0, 13, "rd6");
        chk("midchg_line6", if0.rd_line, pat(32'hE0));
        txn(0, 1'b0, 7'd5, '0, 13, "rd5b");
        chk("midchg_line5", if0.rd_line, pat(32'h28));
        txn(0, 1'b0, 7'd7, '0, 13, "rd7");
        chk("midchg_line7", if0.rd_line, pat(32'hD0));

        txn(0, 1'b1, 7'd4, pat(32'h11110000), 13, "wr4_old");
        drive(0, 1'b1, 1'b0, 7'd4, pat(32'h22220000));
        gcount = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (if0.gnt === 1'b1) gcount++;
        end
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 7'd0, '0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_gnt", 256'(if0.gnt), 256'(0));
        chk("rst_rd_line", if0.rd_line, '0);
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (if0.gnt === 1'b1) gcount++;
        end
        chk("rst_no_gnt", 256'(gcount), 256'(0));
        txn(0, 1'b0, 7'd4, '0, 13, "rd4");
        for (int i = 0; i < 8; i++)
            mixed[i*32 +: 32] = (i < 3) ? 32'h22220000 + 32'(i) : 32'h11110000 + 32'(i);
        chk("rst_partial_line4", if0.rd_line, mixed);

        txn(1, 1'b1, 7'd1, pat(32'h300), 9, "lat0_wr");
        drive(1, 1'b0, 1'b1, 7'd1, '0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, 7'd0, '0);
        wait_gnt(1, c);
        chk("lat0_drop_gnt_cycle", 256'((c < 0) ? c : c + 1), 256'(9));
        chk("lat0_rd_data", if1.rd_line, pat(32'h300));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
